ro_bank_sampler: RTL and testbench

//  Parametrised successor to the single clocked ring oscillator: a bank of NUM_CH emulated rings
//  (STAGES-bit shift-invert ring, NAND-gated enable) with per-channel programmable advance delay.

---
 rtl/ro_pkg.sv | 20 ++
 rtl/ro_channel.sv | 63 ++++++
 rtl/ro_bank_sampler.sv | 113 +++++++++++
 tb/tb_ro_bank_sampler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_pkg.sv
// Shared definitions for the ring-oscillator bank sampler.
// Holds the measurement FSM state encoding, default ring geometry/seed and
// the saturating increment used by the per-channel edge counters.
package ro_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int                    DEF_STAGES = 13;
  localparam logic [DEF_STAGES-1:0] DEF_SEED   = 13'h1555;

  // Increment that sticks at 'max' instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
    return (val >= max) ? max : val + 32'd1;
  endfunction

endpackage

// File: rtl/ro_channel.sv
// One emulated ring oscillator: shift-invert ring, advance divider and saturating rising-edge counter.
// Latency: ring/counter update on the cycle the divider wraps; ro_out and count are direct register outputs.
// Backpressure: none; load overrides run, and the channel is frozen whenever run is low.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   load            restart: ring=SEED, divider/counter cleared
//   run             advance enable for this cycle (divider counts, ring may tick)
//   en              NAND enable of the ring feedback
//   dly             ring ticks every dly+1 run cycles
//   ro_out, count   ring output bit and rising-edge count
module ro_channel
  import ro_pkg::*;
#(
  parameter int                STAGES = DEF_STAGES,
  parameter logic [STAGES-1:0] SEED   = DEF_SEED,
  parameter int                DLY_W  = 4,
  parameter int                CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic             en,
  input  logic [DLY_W-1:0] dly,
  output logic             ro_out,
  output logic [CNT_W-1:0] count
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [STAGES-1:0] ring;
  logic [STAGES-1:0] ring_nxt;
  logic [DLY_W-1:0]  div;
  logic              prev_out;
  logic              rise;

  // Each tick shifts the inverted ring up one place; the NAND closes the loop,
  // so with en=0 the seed pattern reproduces itself and the output sticks high.
  assign ring_nxt = {~ring[STAGES-2:0], ~(en & ring[STAGES-1])};
  assign rise     = ring_nxt[STAGES-1] & ~prev_out;
  assign ro_out   = ring[STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst || load) begin
      ring     <= SEED;
      div      <= '0;
      prev_out <= SEED[STAGES-1];
      count    <= '0;
    end else if (run) begin
      if (div == dly) begin
        div      <= '0;
        ring     <= ring_nxt;
        prev_out <= ring_nxt[STAGES-1];
        if (rise) begin
          count <= CNT_W'(sat_inc(32'(count), CNT_MAX));
        end
      end else begin
        div <= div + DLY_W'(1);
      end
    end
  end

endmodule

// File: rtl/ro_bank_sampler.sv
// Bank of NUM_CH ring-oscillator channels counting ring rising edges over a programmable window.
// Latency: busy rises the cycle after an accepted start; done rises max(win_len,1) cycles later.
// Backpressure: start is only accepted in IDLE/DONE; a start during RUN is dropped.
// Ports:
//   clk, rst   clock, synchronous active-low reset (aborts a run)
//   start      measurement request pulse
//   win_len    window length in cycles, latched on accepted start
//   ch_en      per-channel ring enable, latched on accepted start
//   cfg_dly    per-channel advance delay (DLY_W each, ch0 at LSBs), latched on accepted start
//   busy       measurement running
//   done       measurement finished, held until the next accepted start
//   ro_out     ring output of each channel
//   counts     per-channel rising-edge counts (CNT_W each, ch0 at LSBs)
module ro_bank_sampler
  import ro_pkg::*;
#(
  parameter int                NUM_CH = 16,
  parameter int                STAGES = DEF_STAGES,
  parameter logic [STAGES-1:0] SEED   = DEF_SEED,
  parameter int                DLY_W  = 4,
  parameter int                CNT_W  = 16,
  parameter int                WIN_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIN_W-1:0]        win_len,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*DLY_W-1:0] cfg_dly,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CH-1:0]       ro_out,
  output logic [NUM_CH*CNT_W-1:0] counts
);

  state_t                  state_q;
  state_t                  state_d;
  logic                    accept;
  logic                    adv;
  logic                    last;
  logic [WIN_W-1:0]        win_cnt;
  logic [WIN_W-1:0]        win_len_q;
  logic [NUM_CH-1:0]       ch_en_q;
  logic [NUM_CH*DLY_W-1:0] cfg_dly_q;

  // win_cnt holds the number of RUN cycles already completed; a zero-length
  // window spends one RUN cycle without advancing the rings.
  assign last = (win_len_q == '0) || (win_cnt == win_len_q - WIN_W'(1));

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    adv     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        adv = (win_len_q != '0);
        if (last) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      win_cnt   <= '0;
      win_len_q <= '0;
      ch_en_q   <= '0;
      cfg_dly_q <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
      if (accept) begin
        win_cnt   <= '0;
        win_len_q <= win_len;
        ch_en_q   <= ch_en;
        cfg_dly_q <= cfg_dly;
      end else if (adv) begin
        win_cnt <= win_cnt + WIN_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ro_channel #(
      .STAGES (STAGES),
      .SEED   (SEED),
      .DLY_W  (DLY_W),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .load   (accept),
      .run    (adv),
      .en     (ch_en_q[i]),
      .dly    (cfg_dly_q[i*DLY_W +: DLY_W]),
      .ro_out (ro_out[i]),
      .count  (counts[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_ro_bank_sampler.sv
// Directed self-checking bench for ro_bank_sampler.
// Main instance: 16 channels, 16-bit counters. Second instance: 2 channels with
// 3-bit counters for the saturation case.
module tb_ro_bank_sampler;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] win_len;
  logic [15:0] ch_en;
  logic [63:0] cfg_dly;
  logic        busy;
  logic        done;
  logic [15:0] ro_out;
  logic [255:0] counts;

  logic        b_start;
  logic [15:0] b_win_len;
  logic [1:0]  b_ch_en;
  logic [7:0]  b_cfg_dly;
  logic        b_busy;
  logic        b_done;
  logic [1:0]  b_ro_out;
  logic [5:0]  b_counts;

  int n_tests;
  int n_fail;

  ro_bank_sampler dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .win_len (win_len),
    .ch_en   (ch_en),
    .cfg_dly (cfg_dly),
    .busy    (busy),
    .done    (done),
    .ro_out  (ro_out),
    .counts  (counts)
  );

  ro_bank_sampler #(.NUM_CH(2), .CNT_W(3)) dut_sat (
    .clk     (clk),
    .rst     (rst),
    .start   (b_start),
    .win_len (b_win_len),
    .ch_en   (b_ch_en),
    .cfg_dly (b_cfg_dly),
    .busy    (b_busy),
    .done    (b_done),
    .ro_out  (b_ro_out),
    .counts  (b_counts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then count busy cycles (bounded).
  task automatic measure(output int bc);
    start = 1'b1;
    step();
    start = 1'b0;
    bc = 0;
    while (busy && bc < 2000) begin
      bc++;
      step();
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++;
    if (counts !== '0) begin n_fail++; $display("FAIL reset_counts got %h want 0", counts); end
    n_tests++;
    if (ro_out !== 16'hFFFF) begin n_fail++; $display("FAIL reset_ro_out got %h want ffff", ro_out); end
  endtask

  task automatic test_basic();
    int bc;
    cfg_dly = '0;
    ch_en   = 16'hFFFF;
    win_len = 16'd256;
    measure(bc);
    n_tests++;
    if (bc !== 256) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 256", bc); end
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", done); end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (counts[i*16 +: 16] !== 16'd9) begin
        n_fail++;
        $display("FAIL basic_count[%0d] got %0d want 9", i, counts[i*16 +: 16]);
      end
    end
    // 256 ticks: 256 mod 26 = 22, inside the low half-period
    n_tests++;
    if (ro_out !== 16'h0000) begin n_fail++; $display("FAIL basic_ro_out got %h want 0000", ro_out); end
    for (int k = 0; k < 5; k++) step();
    n_tests++;
    if (counts[15:0] !== 16'd9 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_frozen got count %0d done %b want 9 1", counts[15:0], done);
    end
  endtask

  task automatic test_dly();
    int bc;
    cfg_dly       = '0;
    cfg_dly[7:4]  = 4'd1;
    cfg_dly[11:8] = 4'd3;
    ch_en   = 16'hFFFF;
    win_len = 16'd256;
    measure(bc);
    n_tests++;
    if (bc !== 256) begin n_fail++; $display("FAIL dly_busy_cycles got %0d want 256", bc); end
    n_tests++;
    if (counts[15:0] !== 16'd9) begin n_fail++; $display("FAIL dly_count0 got %0d want 9", counts[15:0]); end
    n_tests++;
    if (counts[31:16] !== 16'd4) begin n_fail++; $display("FAIL dly_count1 got %0d want 4", counts[31:16]); end
    n_tests++;
    if (counts[47:32] !== 16'd2) begin n_fail++; $display("FAIL dly_count2 got %0d want 2", counts[47:32]); end
    // ch1: 128 ticks (phase 24, low); ch2: 64 ticks (phase 12, high)
    n_tests++;
    if (ro_out[2:0] !== 3'b100) begin n_fail++; $display("FAIL dly_ro_out got %b want 100", ro_out[2:0]); end
  endtask

  task automatic test_sat();
    int bc;
    b_cfg_dly = '0;
    b_ch_en   = 2'b11;
    b_win_len = 16'd256;
    b_start   = 1'b1;
    step();
    b_start = 1'b0;
    bc = 0;
    while (b_busy && bc < 2000) begin
      bc++;
      step();
    end
    n_tests++;
    if (bc !== 256) begin n_fail++; $display("FAIL sat_busy_cycles got %0d want 256", bc); end
    n_tests++;
    if (b_counts !== 6'o77) begin n_fail++; $display("FAIL sat_counts got %o want 77", b_counts); end
    n_tests++;
    if (b_done !== 1'b1) begin n_fail++; $display("FAIL sat_done got %b want 1", b_done); end
  endtask

  task automatic test_ch_en();
    int bc;
    cfg_dly = '0;
    ch_en   = 16'hFFDF;
    win_len = 16'd256;
    measure(bc);
    n_tests++;
    if (counts[95:80] !== 16'd0) begin n_fail++; $display("FAIL chen_count5 got %0d want 0", counts[95:80]); end
    n_tests++;
    if (ro_out[5] !== 1'b1) begin n_fail++; $display("FAIL chen_ro_out5 got %b want 1", ro_out[5]); end
    n_tests++;
    if (counts[79:64] !== 16'd9) begin n_fail++; $display("FAIL chen_count4 got %0d want 9", counts[79:64]); end
    n_tests++;
    if (counts[111:96] !== 16'd9) begin n_fail++; $display("FAIL chen_count6 got %0d want 9", counts[111:96]); end
  endtask

  task automatic test_start_ignored();
    int bc;
    cfg_dly = '0;
    ch_en   = 16'hFFFF;
    win_len = 16'd256;
    start = 1'b1;
    step();
    start = 1'b0;
    win_len = 16'd5;
    bc = 0;
    while (busy && bc < 2000) begin
      bc++;
      start = (bc == 100);
      step();
    end
    start = 1'b0;
    n_tests++;
    if (bc !== 256) begin n_fail++; $display("FAIL ignore_busy_cycles got %0d want 256", bc); end
    n_tests++;
    if (counts[15:0] !== 16'd9 || counts[255:240] !== 16'd9) begin
      n_fail++;
      $display("FAIL ignore_counts got %0d/%0d want 9/9", counts[15:0], counts[255:240]);
    end
  endtask

  task automatic test_back_to_back();
    // Accepted directly from DONE with a zero-length window.
    win_len = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_run got busy %b done %b want 1 0", busy, done);
    end
    step();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done got busy %b done %b want 0 1", busy, done);
    end
    n_tests++;
    if (counts !== '0) begin n_fail++; $display("FAIL zero_counts got %h want 0", counts); end
    n_tests++;
    if (ro_out !== 16'hFFFF) begin n_fail++; $display("FAIL zero_ro_out got %h want ffff", ro_out); end
  endtask

  task automatic test_mid_reset();
    int bc;
    cfg_dly = '0;
    ch_en   = 16'hFFFF;
    win_len = 16'd256;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 49; k++) step();
    n_tests++;
    if (counts[15:0] !== 16'd1) begin n_fail++; $display("FAIL midrst_pre_count got %0d want 1", counts[15:0]); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_flags got busy %b done %b want 0 0", busy, done);
    end
    n_tests++;
    if (counts !== '0) begin n_fail++; $display("FAIL midrst_counts got %h want 0", counts); end
    n_tests++;
    if (ro_out !== 16'hFFFF) begin n_fail++; $display("FAIL midrst_ro_out got %h want ffff", ro_out); end
    measure(bc);
    n_tests++;
    if (bc !== 256) begin n_fail++; $display("FAIL midrst_rerun_cycles got %0d want 256", bc); end
    n_tests++;
    if (counts[127:112] !== 16'd9 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_rerun got count %0d done %b want 9 1", counts[127:112], done);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b0;
    start     = 1'b0;
    win_len   = '0;
    ch_en     = '0;
    cfg_dly   = '0;
    b_start   = 1'b0;
    b_win_len = '0;
    b_ch_en   = '0;
    b_cfg_dly = '0;
    step();
    step();
    test_reset();
    rst = 1'b1;
    step();
    test_basic();
    test_dly();
    test_sat();
    test_ch_en();
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
